// File: rtl/gb_interrupt_controller.sv
// gb_interrupt_controller: latches peripheral interrupt edges into IF (FF0F), masks
// them with IE (FFFF) and presents the highest-priority enabled request and its vector
// to the CPU over a req/ack handshake. Source edge -> IF in 1 cycle, -> O_INT_REQ in 2.
// Backpressure: a presented request is held, with the vector frozen, until acked or withdrawn.
//
// Ports:
//   I_CLOCK, I_RESET            clock, asynchronous active-high reset
//   I_ADDR, IO_DATA             IO bus address / bidirectional data (driven on matching read)
//   I_RE_L, I_WE_L              active-low bus read/write strobes
//   I_INT_SRC                   peripheral interrupt lines, bit 0 = highest priority
//   I_IME, I_INT_ACK            CPU master enable and acknowledge
//   O_INT_REQ, O_INT_VECTOR     registered request and its vector
//   O_WAKE                      HALT wake indication
//   O_IF_DATA, O_IE_DATA        debug copies of IF / IE
//
// Optional feature: define GB_INTC_HALT_WAKE_EN to get a registered O_WAKE that
// flags any enabled pending interrupt regardless of I_IME; otherwise O_WAKE is 0.

module gb_interrupt_controller #(
  parameter int unsigned NUM_SRC       = 5,
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter int unsigned VECTOR_STRIDE = 8
) (
  input  logic               I_CLOCK,
  input  logic               I_RESET,
  input  logic [15:0]        I_ADDR,
  inout  wire  [7:0]         IO_DATA,
  input  logic               I_RE_L,
  input  logic               I_WE_L,
  input  logic [NUM_SRC-1:0] I_INT_SRC,
  input  logic               I_IME,
  input  logic               I_INT_ACK,
  output logic               O_INT_REQ,
  output logic [15:0]        O_INT_VECTOR,
  output logic               O_WAKE,
  output logic [7:0]         O_IF_DATA,
  output logic [7:0]         O_IE_DATA
);

  localparam int unsigned WIN_W   = $clog2(NUM_SRC);
  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACKWAIT} state_t;

  state_t             state_q;
  logic [NUM_SRC-1:0] src_q;     // previous sample of the source lines
  logic [NUM_SRC-1:0] if_q, if_d;
  logic [7:0]         ie_q;
  logic [WIN_W-1:0]   win_q;     // index of the request being presented
  logic               req_q;
  logic [15:0]        vec_q;

  logic [NUM_SRC-1:0] src_edge;
  logic [NUM_SRC-1:0] pend;
  logic [WIN_W-1:0]   win_idx;
  logic [15:0]        win_vec;
  logic               if_we, ie_we, rd_en, ack_clr;
  logic [7:0]         rd_dat;

  assign src_edge = I_INT_SRC & ~src_q;
  assign pend     = if_q & ie_q[NUM_SRC-1:0];
  assign if_we    = ~I_WE_L && (I_ADDR == ADDR_IF);
  assign ie_we    = ~I_WE_L && (I_ADDR == ADDR_IE);
  assign ack_clr  = (state_q == ST_REQ) && I_INT_ACK;

  // Lowest set index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend[i]) win_idx = WIN_W'(i);
    end
  end

  assign win_vec = VECTOR_BASE + 16'(win_idx) * 16'(VECTOR_STRIDE);

  // IF update order gives precedence: edge set over bus write over ack clear.
  always_comb begin
    if_d = if_q;
    if (ack_clr) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (win_q == WIN_W'(i)) if_d[i] = 1'b0;
      end
    end
    if (if_we) if_d = IO_DATA[NUM_SRC-1:0];
    if_d = if_d | src_edge;
  end

  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      if_q    <= '0;
      ie_q    <= '0;
      win_q   <= '0;
      req_q   <= 1'b0;
      vec_q   <= '0;
    end else begin
      src_q <= I_INT_SRC;
      if_q  <= if_d;
      if (ie_we) ie_q <= IO_DATA;
      case (state_q)
        ST_IDLE: begin
          if (I_IME && (|pend)) begin
            win_q   <= win_idx;
            vec_q   <= win_vec;
            req_q   <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (I_INT_ACK) begin
            req_q   <= 1'b0;
            state_q <= ST_ACKWAIT;
          end else if (!I_IME || !pend[win_q]) begin
            // Request no longer valid: withdraw, vector keeps its last value.
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_ACKWAIT: begin
          if (!I_INT_ACK) state_q <= ST_IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef GB_INTC_HALT_WAKE_EN
  logic wake_q;
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) wake_q <= 1'b0;
    else         wake_q <= |pend;
  end
  assign O_WAKE = wake_q;
`else
  assign O_WAKE = 1'b0;
`endif

  // Combinational read port; unimplemented IF bits read back as ones.
  assign rd_en  = ~I_RE_L && ((I_ADDR == ADDR_IF) || (I_ADDR == ADDR_IE));
  assign rd_dat = (I_ADDR == ADDR_IF) ? {{(8 - NUM_SRC){1'b1}}, if_q} : ie_q;
  assign IO_DATA = rd_en ? rd_dat : 8'hzz;

  assign O_INT_REQ    = req_q;
  assign O_INT_VECTOR = vec_q;
  assign O_IF_DATA    = {{(8 - NUM_SRC){1'b1}}, if_q};
  assign O_IE_DATA    = ie_q;

endmodule
